regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
- Write-port controller for the 32x32 register file.
- Owns the single write port (RegWEn/AddrD/DataD) and shares it between two requesters: the in-order pipeline writeback stage and a multi-cycle execution unit (mul/div, late loads).
- After reset it sequences an explicit clear of all 32 registers through the same write port, so the register file needs no reset logic of its own.
- Exposes a pending-write mask for the hazard unit.

Parameters:
- DEPTH, 4, multi-cycle result FIFO entries; power of 2, >=2.
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may be blocked by pipeline writeback before stall_req asserts.
- INIT_VALUE, 32'h0, value written to every register during the clear sequence.

Ports:
- clk  input  1  clock, posedge.
- rst  input  1  reset, asynchronous, active-low.
- wb_valid  input  1  pipeline writeback request; no backpressure, always consumed in RUN.
- wb_addr  input  5  pipeline destination register.
- wb_data  input  32  pipeline result.
- mc_valid  input  1  multi-cycle unit result valid.
- mc_ready  output  1  FIFO can accept a result.
- mc_addr  input  5  multi-cycle destination register.
- mc_data  input  32  multi-cycle result.
- rf_we  output  1  to register file RegWEn; registered.
- rf_addr  output  5  to AddrD; registered.
- rf_data  output  32  to DataD; registered.
- init_busy  output  1  clear sequence active; pipeline must hold.
- stall_req  output  1  request one pipeline bubble so the FIFO can drain.
- pend_mask  output  32  bit i set while any FIFO entry targets register i.

Behaviour:
- Reset (rst low, asynchronous):
  - state=INIT, init counter=0, FIFO flushed, starve counter=0.
  - rf_we=0, rf_addr=0, rf_data=0, init_busy=1, mc_ready=0, stall_req=0, pend_mask=0.
- Reset mid-operation: FIFO contents are discarded and the full clear sequence restarts.
- States: INIT -> RUN only.
- INIT:
  - Each posedge registers rf_we=1, rf_addr=cnt, rf_data=INIT_VALUE, then cnt++.
  - This produces 32 writes, addr 0..31, on the first 32 edges after reset release.
  - The edge that registers the addr-31 write moves the state to RUN.
  - init_busy=1 throughout INIT; wb_valid is ignored and mc_ready=0.
- RUN, each posedge, priority order:
  - (1) wb_valid && wb_addr!=0: register that write.
  - (2) else if FIFO non-empty: pop the head and register its write.
  - (3) else rf_we=0.
  - wb_valid with wb_addr=0 is dropped and does not take the port.
- Write latency: a request sampled at edge N appears on rf_* during cycle N..N+1. The register file commits it on the following negedge.
- FIFO:
  - mc_ready = RUN && !full. There is no same-cycle pass-through when full, even if a pop occurs that edge.
  - Handshake: the transfer occurs at the posedge where mc_valid && mc_ready.
  - mc_addr=0 completes the handshake but is not enqueued.
  - Push and pop on the same edge are allowed; occupancy is unchanged.
  - Earliest write of a pushed entry is the edge after the push. FIFO order is strict, and wr/rd pointers wrap modulo DEPTH.
- Starve counter:
  - Increments on each RUN edge where the FIFO is non-empty and a pipeline write takes the port.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - stall_req = (cnt >= STARVE_LIMIT), driven from the registered counter.
- Same-register ordering: a later wb write to register r may overtake an older FIFO entry for r. The hazard unit prevents this via pend_mask; this block does not reorder.

Optional Feature:
- Macro REGFILE_WB_SCOREBOARD_EN.
- Defined: pend_mask = OR over valid FIFO entries of onehot(addr), combinational from FIFO state. A bit clears only when no remaining entry targets that register, and bit 0 is always 0.
- Undefined: pend_mask is tied to 32'h0 and the hazard unit falls back to stalling while mc_valid or the FIFO is non-empty.

Test Plan:
- Release rst, idle inputs -> 32 consecutive cycles rf_we=1, rf_addr=0..31, rf_data=0; init_busy falls in the cycle showing addr 31; mc_ready=1 afterwards.
- In RUN, wb_valid=1, addr=5, data=32'hDEADBEEF at edge N -> rf_we=1, rf_addr=5, rf_data=32'hDEADBEEF after edge N; wb_addr=0 -> rf_we=0.
- Push mc results (3,A),(7,B),(3,C) with wb idle -> writes 3/A, 7/B, 3/C on consecutive cycles; pend_mask=0x88 then 0x88 then 0x08 then 0 (scoreboard on).
- Fill DEPTH=4 entries while wb_valid=1 every cycle -> mc_ready=0 when full; stall_req rises after 8 blocked edges; one wb bubble -> one pop, stall_req clears.
- Simultaneous wb (addr 2) and non-empty FIFO -> wb written first, FIFO head written next idle cycle, no entry lost.
- Assert rst with 3 entries queued -> outputs zero immediately, FIFO empty; after release the full 32-write clear repeats and no stale entry is written.

Source files
------------

// File: rtl/regfile_wb_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl_if
//   Bundle of the write-port controller's request/response signals.
//
//   Handshake rules:
//     wb_*  : wb_valid has no backpressure; in RUN a request with a non-zero
//             wb_addr is always consumed on the edge it is sampled.
//     mc_*  : strict valid/ready; a transfer happens on the posedge where
//             mc_valid && mc_ready. mc_valid/mc_addr/mc_data must stay stable
//             until that edge. A transfer with mc_addr == 0 is accepted and
//             dropped.
//     rf_*  : registered write port toward the register file (RegWEn, AddrD,
//             DataD); committed by the register file on the following negedge.
//
//   Modports:
//     master : requester / register-file side (drives wb_*, mc_valid/addr/data)
//     slave  : the controller (drives mc_ready, rf_*, status, dbg_state)
//
//   dbg_state exposes the controller FSM: 0 = INIT (clear sequence), 1 = RUN.
// ---------------------------------------------------------------------------
interface regfile_wb_ctrl_if;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        init_busy;
    logic        stall_req;
    logic [31:0] pend_mask;
    logic        dbg_state;

    modport master (
        output wb_valid, wb_addr, wb_data,
        output mc_valid, mc_addr, mc_data,
        input  mc_ready,
        input  rf_we, rf_addr, rf_data,
        input  init_busy, stall_req, pend_mask, dbg_state
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  mc_valid, mc_addr, mc_data,
        output mc_ready,
        output rf_we, rf_addr, rf_data,
        output init_busy, stall_req, pend_mask, dbg_state
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
//   Write-port controller for a 32x32 register file. Owns the single write
//   port and shares it between the pipeline writeback stage (highest
//   priority) and a FIFO of multi-cycle unit results. After reset it clears
//   all 32 registers through the same port so the register file itself needs
//   no reset.
//
//   Ports:
//     clk  : clock, posedge
//     rst  : asynchronous, active-low reset
//     bus  : regfile_wb_ctrl_if.slave
//            wb_valid/wb_addr/wb_data   pipeline writeback request
//            mc_valid/mc_ready/mc_addr/mc_data  multi-cycle result handshake
//            rf_we/rf_addr/rf_data      registered register-file write port
//            init_busy                  clear sequence running
//            stall_req                  FIFO starved; ask for a pipeline bubble
//            pend_mask                  registers targeted by queued results
//            dbg_state                  FSM state (0 INIT, 1 RUN)
//
//   Parameters: DEPTH (FIFO entries, power of 2, >= 2), STARVE_LIMIT,
//   INIT_VALUE (value written during the clear sequence).
//
//   Optional build macro REGFILE_WB_SCOREBOARD_EN: when defined, pend_mask is
//   the OR of onehot(addr) over all queued entries; otherwise it is 0.
// ---------------------------------------------------------------------------
module regfile_wb_ctrl #(
    parameter int          DEPTH        = 4,
    parameter int          STARVE_LIMIT = 8,
    parameter logic [31:0] INIT_VALUE   = 32'h0
) (
    input logic              clk,
    input logic              rst,
    regfile_wb_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t        stateQ, stateD;
    logic [4:0]    initCnt, initCntD;
    logic [PW-1:0] wrPtr, rdPtr;
    logic [PW:0]   count;
    logic [SW-1:0] starveCnt, starveD;
    logic          fifoEmpty, fifoFull, mcReady;
    logic          push, pop, wbTake;
    logic          weD;
    logic [4:0]    addrD;
    logic [31:0]   dataD;
    logic [31:0]   pendMask;

    logic [4:0]    fifoAddr [DEPTH];
    logic [31:0]   fifoData [DEPTH];

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == (PW+1)'(DEPTH));
    // No pass-through: a full FIFO refuses even on an edge that pops.
    assign mcReady   = (stateQ == RUN) && !fifoFull;

    assign bus.mc_ready  = mcReady;
    assign bus.init_busy = (stateQ == INIT);
    assign bus.stall_req = (starveCnt >= SW'(STARVE_LIMIT));
    assign bus.pend_mask = pendMask;
    assign bus.dbg_state = stateQ;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stateQ <= INIT;
        else      stateQ <= stateD;
    end

    // Next state, write-port arbitration, FIFO control, starve counter
    always_comb begin
        stateD   = stateQ;
        initCntD = initCnt;
        weD      = 1'b0;
        addrD    = bus.rf_addr;
        dataD    = bus.rf_data;
        push     = 1'b0;
        pop      = 1'b0;
        wbTake   = 1'b0;
        starveD  = starveCnt;
        case (stateQ)
            INIT: begin
                weD      = 1'b1;
                addrD    = initCnt;
                dataD    = INIT_VALUE;
                initCntD = initCnt + 5'd1;
                if (initCnt == 5'd31) stateD = RUN;
            end
            RUN: begin
                push   = bus.mc_valid && mcReady && (bus.mc_addr != 5'd0);
                // Writes to x0 are dropped and leave the port to the FIFO.
                wbTake = bus.wb_valid && (bus.wb_addr != 5'd0);
                if (wbTake) begin
                    weD   = 1'b1;
                    addrD = bus.wb_addr;
                    dataD = bus.wb_data;
                end else if (!fifoEmpty) begin
                    pop   = 1'b1;
                    weD   = 1'b1;
                    addrD = fifoAddr[rdPtr];
                    dataD = fifoData[rdPtr];
                end
                if (pop || fifoEmpty)
                    starveD = '0;
                else if (wbTake && (starveCnt != SW'(STARVE_LIMIT)))
                    starveD = starveCnt + SW'(1);
            end
            default: stateD = INIT;
        endcase
    end

    // Datapath and control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            initCnt     <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            starveCnt   <= '0;
            bus.rf_we   <= 1'b0;
            bus.rf_addr <= '0;
            bus.rf_data <= '0;
        end else begin
            initCnt     <= initCntD;
            starveCnt   <= starveD;
            bus.rf_we   <= weD;
            bus.rf_addr <= addrD;
            bus.rf_data <= dataD;
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr[wrPtr] <= bus.mc_addr;
            fifoData[wrPtr] <= bus.mc_data;
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    // An entry is live when its distance from the read pointer is below count.
    always_comb begin : pend_calc
        logic [PW-1:0] offs;
        offs     = '0;
        pendMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rdPtr;
            if ({1'b0, offs} < count) pendMask[fifoAddr[i]] = 1'b1;
        end
        pendMask[0] = 1'b0;
    end
`else
    assign pendMask = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_ctrl
//   Directed bench for regfile_wb_ctrl (default parameters: DEPTH=4,
//   STARVE_LIMIT=8, INIT_VALUE=0). Inputs change and outputs are sampled
//   1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_ctrl;
    localparam logic [31:0] INIT_VAL = 32'h0;
`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_ctrl_if bus();

    regfile_wb_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.wb_valid = v;
        bus.wb_addr  = a;
        bus.wb_data  = d;
    endtask

    task automatic set_mc(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.mc_valid = v;
        bus.mc_addr  = a;
        bus.mc_data  = d;
    endtask

    function automatic logic [31:0] pm(input logic [31:0] v);
        return SB ? v : 32'h0;
    endfunction

    // 32-cycle clear sequence, starting right after reset release.
    task automatic check_init_seq(input logic noisy);
        if (noisy) begin
            set_wb(1'b1, 5'd4, 32'h4444_4444);
            set_mc(1'b1, 5'd6, 32'h6666_6666);
        end
        for (int k = 0; k < 32; k++) begin
            step();
            checks++;
            if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, k[4:0], INIT_VAL}) begin
                errors++;
                $display("FAIL init_write[%0d]: got we=%0b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                         k, bus.rf_we, bus.rf_addr, bus.rf_data, k, INIT_VAL);
            end
            checks++;
            if ({bus.init_busy, bus.mc_ready} !== {(k != 31), (k == 31)}) begin
                errors++;
                $display("FAIL init_status[%0d]: got busy=%0b mc_ready=%0b, want busy=%0b mc_ready=%0b",
                         k, bus.init_busy, bus.mc_ready, (k != 31), (k == 31));
            end
        end
        set_wb(1'b0, 5'd0, 32'h0);
        set_mc(1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.dbg_state !== 1'b1) begin
            errors++;
            $display("FAIL init_to_run: got state=%0b, want 1", bus.dbg_state);
        end
    endtask

    task automatic test_reset();
        set_wb(1'b0, 5'd0, 32'h0);
        set_mc(1'b0, 5'd0, 32'h0);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({bus.rf_we, bus.rf_addr, bus.rf_data, bus.init_busy, bus.mc_ready, bus.stall_req, bus.pend_mask}
            !== {1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got we=%0b addr=%0d data=%h busy=%0b rdy=%0b stall=%0b pend=%h, want 0 0 0 1 0 0 0",
                     bus.rf_we, bus.rf_addr, bus.rf_data, bus.init_busy, bus.mc_ready, bus.stall_req, bus.pend_mask);
        end
        step();
        step();
        checks++;
        if ({bus.rf_we, bus.init_busy} !== 2'b01) begin
            errors++;
            $display("FAIL reset_hold: got we=%0b busy=%0b, want we=0 busy=1", bus.rf_we, bus.init_busy);
        end
        rst = 1'b1;
        check_init_seq(1'b0);
        step();
        checks++;
        if ({bus.rf_we, bus.mc_ready} !== 2'b01) begin
            errors++;
            $display("FAIL run_idle: got we=%0b mc_ready=%0b, want we=0 mc_ready=1", bus.rf_we, bus.mc_ready);
        end
    endtask

    task automatic test_wb();
        set_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        checks++;
        if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL wb_write: got we=%0b addr=%0d data=%h, want 1 5 deadbeef",
                     bus.rf_we, bus.rf_addr, bus.rf_data);
        end
        set_wb(1'b1, 5'd0, 32'h1234_5678);
        step();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            errors++;
            $display("FAIL wb_x0_dropped: got we=%0b, want 0", bus.rf_we);
        end
        set_wb(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_fifo_order();
        logic [4:0]  ea [6];
        logic [31:0] ed [6];
        logic [31:0] ep [6];
        ea = '{5'd10, 5'd10, 5'd10, 5'd3, 5'd7, 5'd3};
        ed = '{32'h1, 32'h2, 32'h3, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        ep = '{32'h08, 32'h88, 32'h88, 32'h88, 32'h08, 32'h00};
        // Queue three results while the pipeline holds the port.
        set_wb(1'b1, 5'd10, 32'h1); set_mc(1'b1, 5'd3, 32'hAAAA_0001); step();
        set_wb(1'b1, 5'd10, 32'h2); set_mc(1'b1, 5'd7, 32'hBBBB_0002); step();
        set_wb(1'b1, 5'd10, 32'h3); set_mc(1'b1, 5'd3, 32'hCCCC_0003); step();
        set_wb(1'b0, 5'd0, 32'h0);  set_mc(1'b0, 5'd0, 32'h0);
        // The first three outputs were already sampled; re-check them via the
        // drain that follows plus a final idle cycle.
        for (int i = 3; i < 6; i++) begin
            step();
            checks++;
            if ({bus.rf_we, bus.rf_addr, bus.rf_data, bus.pend_mask} !== {1'b1, ea[i], ed[i], pm(ep[i])}) begin
                errors++;
                $display("FAIL fifo_order[%0d]: got we=%0b addr=%0d data=%h pend=%h, want 1 %0d %h %h",
                         i, bus.rf_we, bus.rf_addr, bus.rf_data, bus.pend_mask, ea[i], ed[i], pm(ep[i]));
            end
        end
        step();
        checks++;
        if ({bus.rf_we, bus.pend_mask} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL fifo_drained: got we=%0b pend=%h, want 0 0", bus.rf_we, bus.pend_mask);
        end
    endtask

    task automatic test_fifo_fill_pend();
        // Same fill pattern, checking the wb writes and pend_mask during fill.
        logic [31:0] ep [3];
        ep = '{32'h08, 32'h88, 32'h88};
        for (int i = 0; i < 3; i++) begin
            set_wb(1'b1, 5'd10, 32'h10 + i);
            case (i)
                0:       set_mc(1'b1, 5'd3, 32'hA);
                1:       set_mc(1'b1, 5'd7, 32'hB);
                default: set_mc(1'b1, 5'd3, 32'hC);
            endcase
            step();
            checks++;
            if ({bus.rf_we, bus.rf_addr, bus.rf_data, bus.pend_mask} !== {1'b1, 5'd10, 32'h10 + i, pm(ep[i])}) begin
                errors++;
                $display("FAIL fill_pend[%0d]: got we=%0b addr=%0d data=%h pend=%h, want 1 10 %h %h",
                         i, bus.rf_we, bus.rf_addr, bus.rf_data, bus.pend_mask, 32'h10 + i, pm(ep[i]));
            end
        end
        set_wb(1'b0, 5'd0, 32'h0); set_mc(1'b0, 5'd0, 32'h0);
        step(); step(); step();
        checks++;
        if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, 5'd3, 32'hC}) begin
            errors++;
            $display("FAIL fill_last: got we=%0b addr=%0d data=%h, want 1 3 0000000c",
                     bus.rf_we, bus.rf_addr, bus.rf_data);
        end
        step();
    endtask

    task automatic test_starve();
        for (int k = 1; k <= 10; k++) begin
            set_wb(1'b1, 5'd1, 32'h100 + k);
            if (k <= 4) set_mc(1'b1, 5'(10 + k), 32'hD000_0000 + k);
            else        set_mc(1'b1, 5'd15, 32'hFFFF_FFFF);
            checks++;
            if (bus.mc_ready !== (k <= 4)) begin
                errors++;
                $display("FAIL starve_ready[%0d]: got %0b, want %0b", k, bus.mc_ready, (k <= 4));
            end
            step();
            checks++;
            if ({bus.stall_req, bus.rf_addr} !== {(k >= 9), 5'd1}) begin
                errors++;
                $display("FAIL starve_stall[%0d]: got stall=%0b addr=%0d, want stall=%0b addr=1",
                         k, bus.stall_req, bus.rf_addr, (k >= 9));
            end
        end
        // One bubble while full and mc_valid still high: pop only, no push.
        set_wb(1'b0, 5'd0, 32'h0);
        step();
        checks++;
        if ({bus.rf_we, bus.rf_addr, bus.rf_data, bus.stall_req, bus.mc_ready} !== {1'b1, 5'd11, 32'hD000_0001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL starve_bubble: got we=%0b addr=%0d data=%h stall=%0b rdy=%0b, want 1 11 d0000001 0 1",
                     bus.rf_we, bus.rf_addr, bus.rf_data, bus.stall_req, bus.mc_ready);
        end
        checks++;
        if (bus.pend_mask !== pm(32'h0000_7000)) begin
            errors++;
            $display("FAIL starve_pend: got %h, want %h", bus.pend_mask, pm(32'h0000_7000));
        end
        set_mc(1'b0, 5'd0, 32'h0);
        set_wb(1'b1, 5'd1, 32'h77);
        step();
        checks++;
        if ({bus.rf_addr, bus.rf_data, bus.stall_req} !== {5'd1, 32'h77, 1'b0}) begin
            errors++;
            $display("FAIL starve_resume: got addr=%0d data=%h stall=%0b, want 1 00000077 0",
                     bus.rf_addr, bus.rf_data, bus.stall_req);
        end
        set_wb(1'b0, 5'd0, 32'h0);
        for (int k = 2; k <= 4; k++) begin
            step();
            checks++;
            if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, 5'(10 + k), 32'hD000_0000 + k}) begin
                errors++;
                $display("FAIL starve_drain[%0d]: got we=%0b addr=%0d data=%h, want 1 %0d %h",
                         k, bus.rf_we, bus.rf_addr, bus.rf_data, 10 + k, 32'hD000_0000 + k);
            end
        end
        step();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            errors++;
            $display("FAIL starve_no_passthru: got we=%0b addr=%0d, want we=0", bus.rf_we, bus.rf_addr);
        end
    endtask

    task automatic test_back_to_back();
        set_wb(1'b1, 5'd2, 32'h2222_0001); set_mc(1'b1, 5'd9, 32'hEEEE_0009);
        step();
        checks++;
        if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, 5'd2, 32'h2222_0001}) begin
            errors++;
            $display("FAIL b2b_wb1: got we=%0b addr=%0d data=%h, want 1 2 22220001",
                     bus.rf_we, bus.rf_addr, bus.rf_data);
        end
        // Result for x0: handshake completes but nothing is queued.
        set_wb(1'b1, 5'd2, 32'h2222_0002); set_mc(1'b1, 5'd0, 32'hBAD0_BAD0);
        step();
        checks++;
        if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, 5'd2, 32'h2222_0002}) begin
            errors++;
            $display("FAIL b2b_wb2: got we=%0b addr=%0d data=%h, want 1 2 22220002",
                     bus.rf_we, bus.rf_addr, bus.rf_data);
        end
        set_wb(1'b0, 5'd0, 32'h0); set_mc(1'b0, 5'd0, 32'h0);
        step();
        checks++;
        if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, 5'd9, 32'hEEEE_0009}) begin
            errors++;
            $display("FAIL b2b_fifo: got we=%0b addr=%0d data=%h, want 1 9 eeee0009",
                     bus.rf_we, bus.rf_addr, bus.rf_data);
        end
        step();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_x0_not_queued: got we=%0b addr=%0d, want we=0", bus.rf_we, bus.rf_addr);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_wb(1'b1, 5'd1, 32'h300 + i);
            set_mc(1'b1, 5'(20 + i), 32'h5000_0000 + i);
            step();
        end
        set_wb(1'b0, 5'd0, 32'h0); set_mc(1'b0, 5'd0, 32'h0);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({bus.rf_we, bus.rf_addr, bus.rf_data, bus.init_busy, bus.mc_ready, bus.stall_req, bus.pend_mask}
            !== {1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL midreset_outputs: got we=%0b addr=%0d data=%h busy=%0b rdy=%0b stall=%0b pend=%h, want 0 0 0 1 0 0 0",
                     bus.rf_we, bus.rf_addr, bus.rf_data, bus.init_busy, bus.mc_ready, bus.stall_req, bus.pend_mask);
        end
        step();
        rst = 1'b1;
        check_init_seq(1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus.rf_we, bus.pend_mask} !== {1'b0, 32'h0}) begin
                errors++;
                $display("FAIL midreset_stale[%0d]: got we=%0b addr=%0d pend=%h, want we=0 pend=0",
                         i, bus.rf_we, bus.rf_addr, bus.pend_mask);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wb();
        test_fifo_order();
        test_fifo_fill_pend();
        test_starve();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
